// File: rtl/key_debounce.sv
// Debounces four active-low push-buttons into levels, press/release pulses and a key code.
// Optional long-press pulses are enabled by defining KEY_LONG_PRESS_EN.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    output logic [3:0] key_state,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic [3:0] key_long
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       sync_s;
    logic [3:0]       deb_r;
    logic [3:0]       deb_nxt_s;
    logic [CNT_W-1:0] cnt_r     [4];
    logic [CNT_W-1:0] cnt_nxt_s [4];
    logic [3:0]       rise_s;
    logic [3:0]       fall_s;
    logic [3:0]       press_r;
    logic [3:0]       release_r;
    logic             valid_r;
    logic [1:0]       code_r;
    logic [1:0]       code_s;

    // Lowest set index of a 4-bit vector.
    function automatic logic [1:0] lowest_idx(input logic [3:0] vec);
        logic [1:0] idx;
        casez (vec)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    assign sync_s = ~sync2_r;

    // Per-key stability counter and accept decision.
    always_comb begin
        deb_nxt_s = deb_r;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt_s[i] = {CNT_W{1'b0}};
            if (sync_s[i] == deb_r[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
                deb_nxt_s[i] = deb_r[i];
            end else if (cnt_r[i] == DEB_LAST) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
                deb_nxt_s[i] = sync_s[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                deb_nxt_s[i] = deb_r[i];
            end
        end
        rise_s = deb_nxt_s & ~deb_r;
        fall_s = ~deb_nxt_s & deb_r;
        code_s = lowest_idx(rise_s);
    end

    // Synchroniser, debounced levels and event pulses, all aligned to the same edge.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_r   <= 4'b1111;
            sync2_r   <= 4'b1111;
            deb_r     <= 4'b0000;
            press_r   <= 4'b0000;
            release_r <= 4'b0000;
            valid_r   <= 1'b0;
            code_r    <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_r   <= key_n;
            sync2_r   <= sync1_r;
            deb_r     <= deb_nxt_s;
            press_r   <= rise_s;
            release_r <= fall_s;
            valid_r   <= |rise_s;
            if (|rise_s) begin
                code_r <= code_s;
            end
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign key_state   = deb_r;
    assign key_press   = press_r;
    assign key_release = release_r;
    assign key_valid   = valid_r;
    assign key_code    = code_r;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CYC - 2);

    logic [CNT_W-1:0] hcnt_r [4];
    logic [3:0]       long_r;

    // Hold counter stops at its last value so each press fires at most once.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            long_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                hcnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                long_r[i] <= deb_r[i] && (hcnt_r[i] == LONG_PRE);
                if (!deb_r[i]) begin
                    hcnt_r[i] <= {CNT_W{1'b0}};
                end else if (hcnt_r[i] != LONG_LAST) begin
                    hcnt_r[i] <= hcnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign key_long = long_r;
`else
    assign key_long = 4'b0000;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulses are queued by cycle when keys are driven.
module tb_key_debounce;

    localparam int DEB     = 8;
    localparam int LONG    = 32;
    localparam int DEB_LAT = DEB + 2;

    logic       sys_clk;
    logic       rst;
    logic [3:0] key_n;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic       key_valid;
    logic [1:0] key_code;
    logic [3:0] key_long;

    key_debounce #(.DEBOUNCE_CYC(DEB), .LONG_CYC(LONG), .CNT_W(6)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_long    (key_long)
    );

    typedef struct {
        int         cyc;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
    } ev_t;

    ev_t        q[$];
    int         edge_cnt = 0;
    int         clear_at = -1;
    int         n_chk    = 0;
    int         n_err    = 0;
    logic       mon_en   = 1'b0;
    logic [3:0] acc      = 4'b1111;
    logic [3:0] exp_state = 4'b0000;
    logic [1:0] exp_code  = 2'd0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", tag, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [1:0] low_key(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic void push_ev(input int c, input logic [3:0] pr, input logic [3:0] rl,
                                    input logic [3:0] lg);
        ev_t e;
        int  pos;
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc == c) begin
                q[i].pr = q[i].pr | pr;
                q[i].rl = q[i].rl | rl;
                q[i].lg = q[i].lg | lg;
                return;
            end
            if (q[i].cyc > c && pos == q.size()) pos = i;
        end
        e.cyc = c;
        e.pr  = pr;
        e.rl  = rl;
        e.lg  = lg;
        q.insert(pos, e);
    endfunction

    function automatic void drop_long(input logic [3:0] keys, input int after);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc > after) q[i].lg = q[i].lg & ~keys;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic drive_ev(input logic [3:0] v);
        logic [3:0] pr;
        logic [3:0] rl;
        int         t;
        t  = edge_cnt;
        pr = acc & ~v;
        rl = ~acc & v;
        if (rl != 4'b0000) drop_long(rl, t + DEB_LAT);
        if ((pr | rl) != 4'b0000) push_ev(t + DEB_LAT, pr, rl, 4'b0000);
`ifdef KEY_LONG_PRESS_EN
        if (pr != 4'b0000) push_ev(t + DEB_LAT + LONG - 1, 4'b0000, 4'b0000, pr);
`endif
        acc   = v;
        key_n = v;
    endtask

    task automatic do_reset();
        int t;
        rst      = 1'b1;
        clear_at = edge_cnt + 1;
        drop_long(4'b1111, edge_cnt);
        tick(3);
        rst = 1'b0;
        t   = edge_cnt;
        if (~acc != 4'b0000) begin
            push_ev(t + DEB_LAT, ~acc, 4'b0000, 4'b0000);
`ifdef KEY_LONG_PRESS_EN
            push_ev(t + DEB_LAT + LONG - 1, 4'b0000, 4'b0000, ~acc);
`endif
        end
    endtask

    // Per-cycle comparison of outputs against the queued expectations.
    always @(negedge sys_clk) begin
        ev_t        e;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
        if (mon_en) begin
            pr = 4'b0000;
            rl = 4'b0000;
            lg = 4'b0000;
            if (edge_cnt == clear_at) begin
                exp_state = 4'b0000;
                exp_code  = 2'd0;
            end
            if (q.size() > 0 && q[0].cyc == edge_cnt) begin
                e  = q.pop_front();
                pr = e.pr;
                rl = e.rl;
                lg = e.lg;
            end
            exp_state = (exp_state | pr) & ~rl;
            if (pr != 4'b0000) exp_code = low_key(pr);
            check("key_state",   32'(key_state),   32'(exp_state));
            check("key_press",   32'(key_press),   32'(pr));
            check("key_release", 32'(key_release), 32'(rl));
            check("key_valid",   32'(key_valid),   32'(|pr));
            check("key_code",    32'(key_code),    32'(exp_code));
            check("key_long",    32'(key_long),    32'(lg));
        end
    end

    initial begin
        rst   = 1'b1;
        key_n = 4'b1111;
        tick(3);
        check("rst_state",   32'(key_state),   32'd0);
        check("rst_press",   32'(key_press),   32'd0);
        check("rst_release", 32'(key_release), 32'd0);
        check("rst_valid",   32'(key_valid),   32'd0);
        check("rst_code",    32'(key_code),    32'd0);
        check("rst_long",    32'(key_long),    32'd0);
        mon_en = 1'b1;
        rst    = 1'b0;
        tick(5);

        // clean press and release on key 0
        drive_ev(4'b1110);
        tick(20);
        drive_ev(4'b1111);
        tick(20);

        // bounce on key 2, then settle low
        for (int i = 0; i < 14; i++) begin
            key_n[2] = ~key_n[2];
            tick(3);
        end
        drive_ev(4'b1011);
        tick(20);
        drive_ev(4'b1111);
        tick(20);

        // 7-cycle glitch on key 1 must be ignored
        key_n[1] = 1'b0;
        tick(7);
        key_n[1] = 1'b1;
        tick(20);

        // simultaneous press and release of keys 3 and 1
        drive_ev(4'b0101);
        tick(15);
        drive_ev(4'b1111);
        tick(20);

        // press on key 0 and release on key 3 in the same cycle
        drive_ev(4'b0111);
        tick(15);
        drive_ev(4'b1110);
        tick(15);
        drive_ev(4'b1111);
        tick(20);

        // reset while key 0 is held
        drive_ev(4'b1110);
        tick(15);
        do_reset();
        tick(20);
        drive_ev(4'b1111);
        tick(20);

        // long hold on key 2
        drive_ev(4'b1011);
        tick(60);
        drive_ev(4'b1111);
        tick(50);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
